// File: rtl/ahb_lite_protocol_monitor.sv
// Passive AHB-Lite protocol monitor reporting wait-limit, address, burst-length,
// ERROR-response and sequencing violations. Define AHB_MON_ADDR_CHECK_EN to build the address tracker.
module ahb_lite_protocol_monitor #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 5,
  parameter int CNT_W    = 16
) (
  input  logic              hclk,
  input  logic              hrst,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic              hreadyout,
  input  logic [1:0]        hresp,
  input  logic              clr,
  output logic [4:0]        err_pulse,
  output logic [4:0]        err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  xfer_count
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

  localparam logic [1:0]       TR_IDLE    = 2'b00;
  localparam logic [1:0]       TR_BUSY    = 2'b01;
  localparam logic [1:0]       TR_NONSEQ  = 2'b10;
  localparam logic [1:0]       TR_SEQ     = 2'b11;
  localparam logic [1:0]       RESP_ERROR = 2'b01;
  localparam logic [2:0]       BURST_SGL  = 3'b000;
  localparam logic [8:0]       WAIT_LIMIT = 9'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // Beats remaining after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [3:0] burst_left(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4'd3;
      3'd4, 3'd5: return 4'd7;
      3'd6, 3'd7: return 4'd15;
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic burst_fixed(input logic [2:0] b);
    return (b >= 3'd2);
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  left_q, left_d;
  logic        fixed_q, fixed_d;
  logic        phase_q, phase_d;
  logic [8:0]  wait_q, wait_d;
  logic        errwait_q, errwait_d;
  logic [4:0]  pulse_q, pulse_d;
  logic [4:0]  sticky_q, sticky_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;

  logic        accept_s, nonseq_s, seq_s, err_resp_s, err_done_s;
  logic        start_s, seq_beat_s, len_err_s, addr_err_s;
  logic        wait_err_s, resp_err_s, seq_err_s, any_err_s;
  logic [4:0]  pulse_s;

  assign accept_s   = hreadyout & htrans[1];
  assign nonseq_s   = accept_s & (htrans == TR_NONSEQ);
  assign seq_s      = accept_s & (htrans == TR_SEQ);
  assign err_resp_s = (hresp == RESP_ERROR);
  assign err_done_s = err_resp_s & hreadyout;

  // Burst FSM: next state, beat bookkeeping and the LEN check.
  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    fixed_d    = fixed_q;
    start_s    = 1'b0;
    seq_beat_s = 1'b0;
    len_err_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (nonseq_s && (hburst != BURST_SGL)) begin
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (nonseq_s) begin
          len_err_s = fixed_q & (left_q != 4'd0) & ~err_resp_s;
          if (hburst != BURST_SGL) begin
            start_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (err_done_s) begin
          // A completed ERROR response legitimately abandons the burst.
          state_d = ST_IDLE;
        end else if (hreadyout && (htrans == TR_IDLE)) begin
          len_err_s = fixed_q & (left_q != 4'd0);
          state_d   = ST_IDLE;
        end else if (seq_s) begin
          seq_beat_s = 1'b1;
          if (fixed_q) begin
            left_d = left_q - 4'd1;
            if (left_q == 4'd1) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_BURST;
            end
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_s) begin
      state_d = ST_BURST;
      left_d  = burst_left(hburst);
      fixed_d = burst_fixed(hburst);
    end else begin
      fixed_d = fixed_d;
    end
  end

`ifdef AHB_MON_ADDR_CHECK_EN
  function automatic logic [ADDR_W-1:0] wrap_mask(input logic [2:0] b, input logic [2:0] s);
    logic [ADDR_W-1:0] beats;
    beats = ADDR_W'(burst_left(b)) + ADDR_W'(1);
    return (beats << s) - ADDR_W'(1);
  endfunction

  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d, mask_q, mask_d;
  logic [ADDR_W-1:0] base_s, inc_s, mask_s, next_addr_s;
  logic [2:0]        size_q, size_d;
  logic              wrap_q, wrap_d, wrap_s;
  logic              unused_s;

  assign unused_s = hwrite;

  // Expected-address tracker; the chain follows the expected sequence, not the observed one.
  always_comb begin
    base_s = start_s ? haddr : exp_addr_q;
    inc_s  = ADDR_W'(1) << (start_s ? hsize : size_q);
    mask_s = start_s ? wrap_mask(hburst, hsize) : mask_q;
    wrap_s = start_s ? ((hburst != BURST_SGL) & ~hburst[0]) : wrap_q;
    if (wrap_s) begin
      next_addr_s = (base_s & ~mask_s) | ((base_s + inc_s) & mask_s);
    end else begin
      next_addr_s = base_s + inc_s;
    end
    addr_err_s = seq_beat_s & (haddr != exp_addr_q);
    exp_addr_d = exp_addr_q;
    mask_d     = mask_q;
    size_d     = size_q;
    wrap_d     = wrap_q;
    if (start_s) begin
      exp_addr_d = next_addr_s;
      mask_d     = mask_s;
      size_d     = hsize;
      wrap_d     = wrap_s;
    end else if (seq_beat_s) begin
      exp_addr_d = next_addr_s;
    end else begin
      exp_addr_d = exp_addr_q;
    end
  end

  // Address tracker registers.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      exp_addr_q <= '0;
      mask_q     <= '0;
      size_q     <= 3'd0;
      wrap_q     <= 1'b0;
    end else begin
      exp_addr_q <= exp_addr_d;
      mask_q     <= mask_d;
      size_q     <= size_d;
      wrap_q     <= wrap_d;
    end
  end
`else
  logic unused_s;

  assign unused_s   = ^{hwrite, haddr, hsize};
  assign addr_err_s = 1'b0;
`endif

  // Data-phase tracking, wait counter and the remaining per-cycle checks.
  always_comb begin
    if (accept_s) begin
      phase_d = 1'b1;
    end else if (hreadyout) begin
      phase_d = 1'b0;
    end else begin
      phase_d = phase_q;
    end
    wait_err_s = phase_q & ~hreadyout & (wait_q == WAIT_LIMIT);
    if (phase_q && !hreadyout) begin
      // Saturating one past the limit keeps the flag to one per data phase.
      wait_d = (wait_q > WAIT_LIMIT) ? wait_q : wait_q + 9'd1;
    end else begin
      wait_d = 9'd0;
    end
    errwait_d  = err_resp_s & ~hreadyout;
    resp_err_s = err_done_s & ~errwait_q;
    seq_err_s  = (state_q == ST_IDLE) & ((htrans == TR_SEQ) | (htrans == TR_BUSY));
    pulse_s    = {seq_err_s, resp_err_s, len_err_s, addr_err_s, wait_err_s};
    any_err_s  = |pulse_s;
  end

  // Flag and counter next state; a new violation wins over clr.
  always_comb begin
    pulse_d = pulse_s;
    if (clr) begin
      sticky_d = pulse_s;
      errcnt_d = any_err_s ? CNT_ONE : '0;
      xfer_d   = accept_s ? CNT_ONE : '0;
    end else begin
      sticky_d = sticky_q | pulse_s;
      if (any_err_s && (errcnt_q != CNT_MAX)) begin
        errcnt_d = errcnt_q + CNT_ONE;
      end else begin
        errcnt_d = errcnt_q;
      end
      if (accept_s && (xfer_q != CNT_MAX)) begin
        xfer_d = xfer_q + CNT_ONE;
      end else begin
        xfer_d = xfer_q;
      end
    end
  end

  // Monitor state and output registers.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q   <= ST_IDLE;
      left_q    <= 4'd0;
      fixed_q   <= 1'b0;
      phase_q   <= 1'b0;
      wait_q    <= 9'd0;
      errwait_q <= 1'b0;
      pulse_q   <= 5'd0;
      sticky_q  <= 5'd0;
      errcnt_q  <= '0;
      xfer_q    <= '0;
    end else begin
      state_q   <= state_d;
      left_q    <= left_d;
      fixed_q   <= fixed_d;
      phase_q   <= phase_d;
      wait_q    <= wait_d;
      errwait_q <= errwait_d;
      pulse_q   <= pulse_d;
      sticky_q  <= sticky_d;
      errcnt_q  <= errcnt_d;
      xfer_q    <= xfer_d;
    end
  end

  assign err_pulse  = pulse_q;
  assign err_sticky = sticky_q;
  assign err_count  = errcnt_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_ahb_lite_protocol_monitor.sv
// Bench for ahb_lite_protocol_monitor: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a rule-level model.
module tb_ahb_lite_protocol_monitor;
  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 5;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef AHB_MON_ADDR_CHECK_EN
  localparam bit ADDR_EN = 1'b1;
`else
  localparam bit ADDR_EN = 1'b0;
`endif

  logic              hclk = 1'b0;
  logic              hrst;
  logic [ADDR_W-1:0] haddr;
  logic [2:0]        hburst, hsize;
  logic [1:0]        htrans;
  logic              hwrite, hreadyout;
  logic [1:0]        hresp;
  logic              clr;
  logic [4:0]        err_pulse, err_sticky;
  logic [CNT_W-1:0]  err_count, xfer_count;

  ahb_lite_protocol_monitor #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .hclk(hclk), .hrst(hrst), .haddr(haddr), .hburst(hburst), .hsize(hsize),
    .htrans(htrans), .hwrite(hwrite), .hreadyout(hreadyout), .hresp(hresp), .clr(clr),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_count(err_count), .xfer_count(xfer_count)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int failures = 0;

  // Model state: a burst is "active" with a count of beats still owed.
  bit          m_burst, m_fixed, m_wrap, m_pending, m_prev_errwait;
  int          m_left, m_wait, m_beats, m_inc, m_errcnt, m_xfer;
  logic [31:0] m_exp;
  logic [4:0]  m_pulse, m_sticky;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] a);
    int unsigned span;
    logic [31:0] base;
    if (!m_wrap) return a + m_inc;
    span = m_beats * m_inc;
    base = a - (a % span);
    return base + ((a - base + m_inc) % span);
  endfunction

  task automatic model_reset();
    m_burst = 0; m_fixed = 0; m_wrap = 0; m_pending = 0; m_prev_errwait = 0;
    m_left = 0; m_wait = 0; m_beats = 1; m_inc = 1; m_errcnt = 0; m_xfer = 0;
    m_exp = 0; m_pulse = 0; m_sticky = 0;
  endtask

  task automatic model_start();
    case (hburst)
      3'd2, 3'd3: m_beats = 4;
      3'd4, 3'd5: m_beats = 8;
      3'd6, 3'd7: m_beats = 16;
      default:    m_beats = 1;
    endcase
    m_burst = (hburst != 3'd0);
    m_fixed = (hburst >= 3'd2);
    m_wrap  = (hburst == 3'd2) || (hburst == 3'd4) || (hburst == 3'd6);
    m_inc   = 1 << hsize;
    m_left  = m_beats - 1;
    m_exp   = model_next(haddr);
  endtask

  task automatic model_step();
    logic [4:0] p;
    bit acc;
    p   = 5'd0;
    acc = hreadyout && htrans[1];
    if (m_pending && !hreadyout) begin
      m_wait++;
      if (m_wait == MAX_WAIT + 1) p[0] = 1'b1;
    end else begin
      m_wait = 0;
    end
    if (!m_burst && (htrans == 2'b11 || htrans == 2'b01)) p[4] = 1'b1;
    if (hresp == 2'b01 && hreadyout && !m_prev_errwait) p[3] = 1'b1;
    if (m_burst) begin
      if (acc && htrans == 2'b10) begin
        if (m_fixed && m_left > 0 && hresp != 2'b01) p[2] = 1'b1;
        model_start();
      end else if (hresp == 2'b01 && hreadyout) begin
        m_burst = 0;
      end else if (hreadyout && htrans == 2'b00) begin
        if (m_fixed && m_left > 0) p[2] = 1'b1;
        m_burst = 0;
      end else if (acc && htrans == 2'b11) begin
        if (ADDR_EN && haddr != m_exp) p[1] = 1'b1;
        m_exp = model_next(m_exp);
        if (m_fixed) begin
          m_left--;
          if (m_left == 0) m_burst = 0;
        end
      end
    end else if (acc && htrans == 2'b10) begin
      model_start();
    end
    m_prev_errwait = (hresp == 2'b01) && !hreadyout;
    if (acc) m_pending = 1;
    else if (hreadyout) m_pending = 0;
    m_pulse = p;
    if (clr) begin
      m_sticky = p;
      m_errcnt = (p != 0) ? 1 : 0;
      m_xfer   = acc ? 1 : 0;
    end else begin
      m_sticky = m_sticky | p;
      if (p != 0 && m_errcnt < CNT_MAX) m_errcnt++;
      if (acc && m_xfer < CNT_MAX) m_xfer++;
    end
  endtask

  // One clock: advance the model on the current inputs, then compare after the edge.
  task automatic tick();
    if (hrst) model_reset();
    else model_step();
    @(posedge hclk);
    #1;
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("err_count", 32'(err_count), 32'(m_errcnt));
    chk("xfer_count", 32'(xfer_count), 32'(m_xfer));
  endtask

  task automatic drv(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b,
                     input logic [2:0] s, input logic rdy, input logic [1:0] rsp);
    htrans = tr; haddr = a; hburst = b; hsize = s; hreadyout = rdy; hresp = rsp;
    hwrite = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(2'b00, 32'h0, 3'd0, 3'd0, 1'b1, 2'b00);
  endtask

  task automatic clear();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  initial begin
    hrst = 1'b1; clr = 1'b0; haddr = 32'h0; hburst = 3'd0; hsize = 3'd0;
    htrans = 2'b00; hwrite = 1'b0; hreadyout = 1'b1; hresp = 2'b00;
    model_reset();
    tick(); tick();
    chk("reset_pulse", 32'(err_pulse), 32'h0);
    chk("reset_sticky", 32'(err_sticky), 32'h0);
    chk("reset_errcnt", 32'(err_count), 32'h0);
    chk("reset_xfer", 32'(xfer_count), 32'h0);
    hrst = 1'b0;
    idle(2);

    // INCR4, word beats, no waits
    drv(2'b10, 32'h100, 3'd3, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h104, 3'd3, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h108, 3'd3, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h10C, 3'd3, 3'd2, 1'b1, 2'b00);
    idle(1);
    chk("incr4_sticky", 32'(err_sticky), 32'h0);
    chk("incr4_xfer", 32'(xfer_count), 32'd4);

    // WRAP4 at 0x38: legal wrap, then a bad second beat
    drv(2'b10, 32'h38, 3'd2, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h3C, 3'd2, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h30, 3'd2, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h34, 3'd2, 3'd2, 1'b1, 2'b00);
    idle(1);
    chk("wrap4_sticky", 32'(err_sticky), 32'h0);
    chk("wrap4_xfer", 32'(xfer_count), 32'd8);
    clear();
    drv(2'b10, 32'h38, 3'd2, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h40, 3'd2, 3'd2, 1'b1, 2'b00);
    chk("wrap4_bad_pulse", 32'(err_pulse), ADDR_EN ? 32'h2 : 32'h0);
    drv(2'b11, 32'h30, 3'd2, 3'd2, 1'b1, 2'b00);
    chk("wrap4_pulse_width", 32'(err_pulse), 32'h0);
    drv(2'b11, 32'h34, 3'd2, 3'd2, 1'b1, 2'b00);
    idle(1);
    chk("wrap4_bad_count", 32'(err_count), ADDR_EN ? 32'd1 : 32'd0);
    clear();

    // Wait limit: MAX_WAIT low cycles legal, one more flags once
    drv(2'b10, 32'h200, 3'd0, 3'd2, 1'b1, 2'b00);
    for (int k = 0; k < MAX_WAIT; k++) drv(2'b00, 32'h0, 3'd0, 3'd0, 1'b0, 2'b00);
    idle(1);
    chk("wait_legal_sticky", 32'(err_sticky), 32'h0);
    drv(2'b10, 32'h200, 3'd0, 3'd2, 1'b1, 2'b00);
    for (int k = 0; k < MAX_WAIT + 1; k++) drv(2'b00, 32'h0, 3'd0, 3'd0, 1'b0, 2'b00);
    chk("wait_over_pulse", 32'(err_pulse), 32'h1);
    drv(2'b00, 32'h0, 3'd0, 3'd0, 1'b0, 2'b00);
    chk("wait_once", 32'(err_pulse), 32'h0);
    idle(1);
    chk("wait_over_sticky", 32'(err_sticky), 32'h1);
    clear();

    // INCR8 cut short by NONSEQ, then by a two-cycle ERROR
    drv(2'b10, 32'h300, 3'd5, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h304, 3'd5, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h308, 3'd5, 3'd2, 1'b1, 2'b00);
    drv(2'b10, 32'h400, 3'd0, 3'd2, 1'b1, 2'b00);
    idle(1);
    chk("len_sticky", 32'(err_sticky), 32'h4);
    clear();
    drv(2'b10, 32'h300, 3'd5, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h304, 3'd5, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h308, 3'd5, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h30C, 3'd5, 3'd2, 1'b0, 2'b01);
    drv(2'b00, 32'h0, 3'd0, 3'd0, 1'b1, 2'b01);
    idle(2);
    chk("err_term_sticky", 32'(err_sticky), 32'h0);

    // Single-cycle ERROR, then SEQ with no burst, then clr
    drv(2'b00, 32'h0, 3'd0, 3'd0, 1'b1, 2'b01);
    drv(2'b11, 32'h10, 3'd0, 3'd2, 1'b1, 2'b00);
    chk("resp_seq_sticky", 32'(err_sticky), 32'h18);
    chk("resp_seq_count", 32'(err_count), 32'd2);
    clear();
    chk("clr_pulse", 32'(err_pulse), 32'h0);
    chk("clr_sticky", 32'(err_sticky), 32'h0);
    chk("clr_errcnt", 32'(err_count), 32'h0);
    chk("clr_xfer", 32'(xfer_count), 32'h0);

    // Counter saturation
    for (int k = 0; k < (1 << CNT_W) + 3; k++) drv(2'b10, 32'(k * 4), 3'd0, 3'd2, 1'b1, 2'b00);
    idle(1);
    chk("xfer_sat", 32'(xfer_count), 32'hF);
    clear();

    // Reset in the middle of an INCR16
    drv(2'b10, 32'h500, 3'd7, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h504, 3'd7, 3'd2, 1'b1, 2'b00);
    drv(2'b11, 32'h508, 3'd7, 3'd2, 1'b1, 2'b00);
    hrst = 1'b1;
    #2;
    chk("hrst_pulse", 32'(err_pulse), 32'h0);
    chk("hrst_sticky", 32'(err_sticky), 32'h0);
    chk("hrst_errcnt", 32'(err_count), 32'h0);
    chk("hrst_xfer", 32'(xfer_count), 32'h0);
    htrans = 2'b00;
    tick();
    hrst = 1'b0;
    idle(3);
    chk("hrst_no_len", 32'(err_sticky), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] tr;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      clr = ($urandom_range(0, 63) == 0);
      if (r < 3) begin
        drv(htrans, haddr, hburst, hsize, 1'b0, 2'b01);
        clr = 1'b0;
        drv(2'b00, 32'h0, 3'd0, 3'd0, 1'b1, 2'b01);
      end else if (r < 5) begin
        int n;
        n = $urandom_range(4, 8);
        for (int k = 0; k < n; k++) drv(htrans, haddr, hburst, hsize, 1'b0, 2'b00);
      end else begin
        if (m_burst && $urandom_range(0, 9) < 7) tr = 2'b11;
        else tr = 2'($urandom_range(0, 3));
        if (tr == 2'b11 && $urandom_range(0, 9) < 8) a = m_exp;
        else a = 32'($urandom_range(0, 32'hFFF));
        drv(tr, a, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 2)),
            1'($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0) ? 2'b01 : 2'b00);
      end
    end
    clr = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
